seq_detect_prog: RTL
====================

Name: seq_detect_prog

Overview:
Runtime-programmable serial bit-sequence detector. It is the parametrised successor to the fixed-pattern Moore detectors in the FSM library.
- Pattern length is a parameter; the pattern itself is loadable at runtime.
- Overlapping or non-overlapping detection is selectable.
- Input bits are qualified by a valid strobe.
- A saturating match counter is included.
- Sits between a serial bit source and control/status logic that needs a match flag plus a match tally.

Parameters:
PAT_W, 4, pattern length in bits (≥2).
PAT_RST, 4'b1010, pattern register value after reset (PAT_W bits).
CNT_W, 8, match counter width.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-low reset
x  input  1  serial data bit
x_valid  input  1  x sampled only when high
ovl  input  1  1 = overlapping detection, 0 = non-overlapping
pat_load  input  1  load pat_in into pattern register this edge
pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit of the sequence
cnt_clr  input  1  synchronous clear of match counter
y  output  1  Moore match flag
match_cnt  output  CNT_W  number of matches since reset/clear, saturating
state  output  clog2(PAT_W+1)  current matched-prefix length, for debug

Behaviour:
- Reset (rst low, asynchronous):
  - pattern register = PAT_RST
  - state = 0, history cleared
  - y = 0, match_cnt = 0
  - Effect is immediate; reset mid-stream discards any partial match.
- State meaning: number of leading pattern bits currently matched, 0..PAT_W.
- Output: y = (state == PAT_W). It is purely a function of the state register (Moore); there is no combinational path from x.
- Sampling: on a rising edge with x_valid=1 and pat_load=0, state advances. The new state is the largest k ≤ PAT_W such that the last k eligible received bits (including x) equal pattern bits [PAT_W-1 : PAT_W-k]. Eligible bits are those received since the last restart point.
- Latency: y rises in the cycle after the edge that sampled the final pattern bit.
- x_valid=0: state, y and match_cnt hold. If state == PAT_W, y stays high until the next valid bit.
- Overlap mode (ovl=1): when leaving state PAT_W, bits of the completed match stay eligible, so the next state is computed per the prefix/suffix rule (KMP fallback). Example for pattern 1010: the next bit 1 goes to state 3.
- Non-overlap mode (ovl=0): a completed match is a restart point, so its bits are not eligible. From state PAT_W, the next valid bit is evaluated as from state 0 (state becomes 1 if x equals the pattern MSB, else 0).
- ovl is sampled together with each valid bit. A change takes effect on the next valid bit.
- Mismatch inside a partial match: use the prefix/suffix fallback, never an unconditional return to 0. Example for pattern 1010: from state 1 with x=1, state stays 1.
- Pattern load: pat_load=1 at an edge writes pat_in to the pattern register, forces state to 0, and clears history. x is ignored that edge. pat_load has priority over x_valid.
- Counter: match_cnt increments by 1 on each edge where state transitions into PAT_W. This is visible in the same cycle y rises. The counter saturates at 2^CNT_W−1.
- Counter clear: cnt_clr=1 sets match_cnt to 0 at that edge. cnt_clr has priority over a simultaneous increment.
- Simultaneous pat_load and cnt_clr: both take effect.
- No X propagation: x is a don't-care when x_valid=0.

Test Plan:
1. Reset default (PAT_W=4, 1010), ovl=1, valid bits 1,0,1,0,1,0 → y high after the 4th and 6th bit edges, each for one cycle; match_cnt=2; state sequence 1,2,3,4,3,4.
2. Same stream with ovl=0 → y high only after the 4th bit; state sequence 1,2,3,4,1,2; match_cnt=1.
3. Fallback: bits 1,1,0,1,0 → states 1,1,2,3,4; y high after the 5th bit; bits 1,0,0 → states 1,2,0.
4. x_valid gaps: bits 1,0,1,0 with x_valid=0 for 3 cycles between each bit and after the last → y stays high for all 4 hold cycles; match_cnt=1, not 4.
5. pat_load with pat_in=4'b1101 issued mid-match at state 3, with x_valid=1 the same edge → state=0, y=0; then bits 1,1,0,1 → match, match_cnt increments.
6. Counter: CNT_W=2, five overlapping matches → match_cnt saturates at 3. Then assert cnt_clr on an edge coinciding with a new match → match_cnt=0 and y=1. Finally, assert rst low asynchronously between clock edges → y=0, match_cnt=0, pattern=1010 immediately.

Source files
------------

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial bit-sequence detector with overlap select,
// valid-qualified input, Moore match flag and saturating match counter.
module seq_detect_prog #(
   parameter int unsigned      PAT_W   = 4,
   parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(4'b1010),
   parameter int unsigned      CNT_W   = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       x,
   input  logic                       x_valid,
   input  logic                       ovl,
   input  logic                       pat_load,
   input  logic [PAT_W-1:0]           pat_in,
   input  logic                       cnt_clr,
   output logic                       y,
   output logic [CNT_W-1:0]           match_cnt,
   output logic [$clog2(PAT_W+1)-1:0] state
);

   localparam int unsigned      SW       = $clog2(PAT_W + 1);
   localparam int unsigned      PIW      = (PAT_W > 1) ? $clog2(PAT_W) : 1;
   localparam logic [SW-1:0]    FULL     = SW'(PAT_W);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   logic [PAT_W-1:0] pat_q, pat_d;
   logic [SW-1:0]    state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             y_q;
   logic [SW-1:0]    eff_s;
   logic             hit;

   // Longest pattern prefix that is a suffix of (matched prefix of length s, then xb).
   // The matched bits are the pattern prefix itself, so no separate history is stored.
   function automatic logic [SW-1:0] next_state(input logic [PAT_W-1:0] p,
                                                input logic [SW-1:0]    s,
                                                input logic             xb);
      logic [PAT_W:0] seq;
      logic           ok;
      logic [SW-1:0]  best;
      seq  = '0;
      best = '0;
      for (int j = 0; j < int'(PAT_W); j++) begin
         if (SW'(j) < s) seq[SW'(j)] = p[PIW'(int'(PAT_W) - 1 - j)];
      end
      seq[s] = xb;
      for (int k = 1; k <= int'(PAT_W); k++) begin
         if (k <= int'(s) + 1) begin
            ok = 1'b1;
            for (int i = 0; i < int'(PAT_W); i++) begin
               if (i < k && seq[SW'(int'(s) + 1 - k + i)] != p[PIW'(int'(PAT_W) - 1 - i)])
                  ok = 1'b0;
            end
            if (ok) best = SW'(k);
         end
      end
      return best;
   endfunction

   // Non-overlap mode restarts after a completed match.
   assign eff_s = (state_q == FULL && !ovl) ? '0 : state_q;

   // Next-state, pattern and counter update.
   always_comb begin
      pat_d   = pat_q;
      state_d = state_q;
      cnt_d   = cnt_q;
      hit     = 1'b0;
      if (pat_load) begin
         pat_d   = pat_in;
         state_d = '0;
      end else if (x_valid) begin
         state_d = next_state(pat_q, eff_s, x);
         hit     = (state_d == FULL);
      end
      if (cnt_clr) begin
         cnt_d = '0;
      end else if (hit && cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pat_q   <= PAT_RST;
         state_q <= '0;
         cnt_q   <= '0;
         y_q     <= 1'b0;
      end else begin
         pat_q   <= pat_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         y_q     <= (state_d == FULL);
      end
   end

   assign y         = y_q;
   assign match_cnt = cnt_q;
   assign state     = state_q;

endmodule
